// File: rtl/apb_slave_regfile_if.sv
// ----------------------------------------------------------------------------
// apb_slave_regfile_if
// APB bus bundle between one master and the apb_slave_regfile slave.
//   PSEL1    master -> slave  slave select
//   PENABLE  master -> slave  access-phase strobe
//   PWRITE   master -> slave  1 = write, 0 = read
//   PADDR    master -> slave  byte address (32 bits)
//   PWDATA   master -> slave  write data (32 bits)
//   PRDATA   slave -> master  read data, non-zero only in the PREADY cycle
//   PREADY   slave -> master  transfer complete
//   PSLVERR  slave -> master  transfer error, qualified by PREADY
//
// Handshake: a transfer is one SETUP cycle (PSEL1=1, PENABLE=0) followed by
// ACCESS cycles (PSEL1=1, PENABLE=1) during which the master holds every
// master->slave signal stable. The transfer completes in the first ACCESS
// cycle that sees PREADY=1; PRDATA and PSLVERR are meaningful only in that
// cycle. The master may not lower PENABLE before PREADY; if it does, the
// slave treats the transfer as abandoned.
// ----------------------------------------------------------------------------
interface apb_slave_regfile_if;
   logic        PSEL1;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   modport master (
      output PSEL1, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL1, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_slave_regfile.sv
// ----------------------------------------------------------------------------
// apb_slave_regfile
// APB slave holding NUM_REGS 32-bit registers with WAIT_CYCLES wait states
// inserted in every ACCESS phase.
//   clk        bus clock, all state on rising edge
//   PRESETn    asynchronous active-low reset
//   bus        apb_slave_regfile_if.slave (PSEL1, PENABLE, PWRITE, PADDR,
//              PWDATA in; PRDATA, PREADY, PSLVERR out)
//   fsm_state  current FSM state for observation: 0 IDLE, 1 SETUP, 2 ACCESS
//
// The state register only ever stores IDLE or ACCESS. SETUP is the cycle in
// which the bus shows PSEL1=1/PENABLE=0 while the register holds IDLE, so it
// is decoded combinationally; this gives a true zero-wait transfer for
// WAIT_CYCLES=0 and lets a new SETUP follow a PREADY cycle directly.
// ----------------------------------------------------------------------------
module apb_slave_regfile #(
   parameter int WAIT_CYCLES = 1,
   parameter int NUM_REGS    = 16
) (
   input  logic                 clk,
   input  logic                 PRESETn,
   apb_slave_regfile_if.slave   bus,
   output logic [1:0]           fsm_state
);

   localparam int IDX_W = $clog2(NUM_REGS);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t            state_q;
   state_t            cur_state;
   state_t            next_state;
   logic [3:0]        wait_cnt;
   logic [31:0]       addr_q;
   logic [31:0]       wdata_q;
   logic              write_q;
   logic [31:0]       regs [NUM_REGS];
   logic              sel_en;
   logic              last_wait;
   logic              ready;
   logic              addr_err;
   logic [IDX_W-1:0]  idx;

   assign sel_en    = bus.PSEL1 && bus.PENABLE;
   assign last_wait = (wait_cnt == 4'(WAIT_CYCLES));
   assign addr_err  = (addr_q[1:0] != 2'b00) || (addr_q >= 32'(4 * NUM_REGS));
   assign idx       = addr_q[IDX_W+1:2];

   // State register
   always_ff @(posedge clk or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q <= IDLE;
      end else begin
         state_q <= next_state;
      end
   end

   // Next-state decode. PSEL1 with PENABLE already high in IDLE is a
   // transfer we never saw the SETUP of, so it is ignored.
   always_comb begin
      cur_state  = state_q;
      next_state = IDLE;
      if (state_q == IDLE && bus.PSEL1 && !bus.PENABLE) begin
         cur_state = SETUP;
      end
      case (cur_state)
         IDLE:    next_state = IDLE;
         SETUP:   next_state = ACCESS;
         // Stay only while the master keeps the access open and the wait
         // count has not run out; completion or abort both return to IDLE.
         ACCESS:  next_state = (sel_en && !last_wait) ? ACCESS : IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      ready       = (cur_state == ACCESS) && last_wait && sel_en;
      bus.PREADY  = ready;
      bus.PSLVERR = ready && addr_err;
      bus.PRDATA  = (ready && !write_q && !addr_err) ? regs[idx] : 32'd0;
      fsm_state   = cur_state;
   end

   // Transfer attributes are captured in SETUP so later bus changes during
   // ACCESS cannot affect the transfer.
   always_ff @(posedge clk or negedge PRESETn) begin
      if (!PRESETn) begin
         wait_cnt <= 4'd0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         write_q  <= 1'b0;
      end else if (cur_state == SETUP) begin
         wait_cnt <= 4'd0;
         addr_q   <= bus.PADDR;
         wdata_q  <= bus.PWDATA;
         write_q  <= bus.PWRITE;
      end else if (cur_state == ACCESS && sel_en && !last_wait) begin
         wait_cnt <= wait_cnt + 4'd1;
      end
   end

   // Register file
   always_ff @(posedge clk or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= 32'd0;
         end
      end else if (ready && write_q && !addr_err) begin
         regs[idx] <= wdata_q;
      end
   end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// ----------------------------------------------------------------------------
// tb_apb_slave_regfile
// Three slaves (WAIT_CYCLES 0, 1, 3) share one set of master signals; sel
// chooses which slave sees PSEL1. A reference model predicts each slave's
// outputs from the transfer being driven and its cycle count since SETUP.
// ----------------------------------------------------------------------------
module tb_apb_slave_regfile;

   localparam int NR = 16;
   localparam int W0 = 0;
   localparam int W1 = 1;
   localparam int W2 = 3;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   // ---------------- master signals and DUTs ----------------
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata;
   int          sel;
   logic        pready, pslverr;
   logic [31:0] prdata;
   logic [1:0]  st0, st1, st2;

   apb_slave_regfile_if bus0 ();
   apb_slave_regfile_if bus1 ();
   apb_slave_regfile_if bus2 ();

   assign bus0.PSEL1 = psel && (sel == 0);
   assign bus1.PSEL1 = psel && (sel == 1);
   assign bus2.PSEL1 = psel && (sel == 2);
   assign bus0.PENABLE = penable;
   assign bus1.PENABLE = penable;
   assign bus2.PENABLE = penable;
   assign bus0.PWRITE = pwrite;
   assign bus1.PWRITE = pwrite;
   assign bus2.PWRITE = pwrite;
   assign bus0.PADDR = paddr;
   assign bus1.PADDR = paddr;
   assign bus2.PADDR = paddr;
   assign bus0.PWDATA = pwdata;
   assign bus1.PWDATA = pwdata;
   assign bus2.PWDATA = pwdata;

   assign pready  = (sel == 0) ? bus0.PREADY  : (sel == 1) ? bus1.PREADY  : bus2.PREADY;
   assign pslverr = (sel == 0) ? bus0.PSLVERR : (sel == 1) ? bus1.PSLVERR : bus2.PSLVERR;
   assign prdata  = (sel == 0) ? bus0.PRDATA  : (sel == 1) ? bus1.PRDATA  : bus2.PRDATA;

   apb_slave_regfile #(.WAIT_CYCLES(W0), .NUM_REGS(NR)) dut0 (
      .clk(clk), .PRESETn(rst_n), .bus(bus0.slave), .fsm_state(st0));
   apb_slave_regfile #(.WAIT_CYCLES(W1), .NUM_REGS(NR)) dut1 (
      .clk(clk), .PRESETn(rst_n), .bus(bus1.slave), .fsm_state(st1));
   apb_slave_regfile #(.WAIT_CYCLES(W2), .NUM_REGS(NR)) dut2 (
      .clk(clk), .PRESETn(rst_n), .bus(bus2.slave), .fsm_state(st2));

   // ---------------- scoreboard / model ----------------
   int vectors    = 0;
   int miscompares = 0;

   logic [31:0] mreg [3][NR];
   bit          t_live  = 1'b0;
   int          t_k     = 0;
   bit          t_wr    = 1'b0;
   logic [31:0] t_addr  = 32'd0;
   logic [31:0] t_wdata = 32'd0;
   int          t_dut   = 0;
   bit          exempt  = 1'b0;

   function automatic int wait_of(input int d);
      case (d)
         0:       return W0;
         1:       return W1;
         default: return W2;
      endcase
   endfunction

   function automatic bit addr_bad(input logic [31:0] a);
      return (a % 4 != 0) || (a >= 4 * NR);
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Every cycle: the selected slave must match what the rules predict.
   always @(negedge clk) begin
      bit          ey, ee, bad;
      logic [31:0] er;
      logic [3:0]  mi;
      if (!rst_n) begin
         for (int d = 0; d < 3; d++)
            for (int i = 0; i < NR; i++)
               mreg[d][i] = 32'd0;
         check32("reset_pready", pready, 32'd0);
         check32("reset_pslverr", pslverr, 32'd0);
         check32("reset_prdata", prdata, 32'd0);
      end else begin
         bad = addr_bad(t_addr);
         mi  = t_addr[5:2];
         ey  = t_live && (t_k == wait_of(t_dut) + 1);
         ee  = ey && bad;
         er  = (ey && !t_wr && !bad) ? mreg[t_dut][mi] : 32'd0;
         check32("pready", pready, {31'd0, ey});
         check32("pslverr", pslverr, {31'd0, ee});
         check32("prdata", prdata, er);
         if (ey && t_wr && !bad) mreg[t_dut][mi] = t_wdata;
      end
   end

   // APB protocol checks on the driven bus.
   logic        p_psel = 1'b0, p_pen = 1'b0, p_rdy = 1'b0, p_wr = 1'b0;
   logic [31:0] p_addr = 32'd0, p_wdata = 32'd0;
   always @(negedge clk) begin
      if (rst_n && !exempt) begin
         if (p_psel && !p_pen)
            check32("proto_penable_after_psel", {30'd0, psel, penable}, 32'd3);
         if (p_psel && p_pen && !p_rdy) begin
            check32("proto_hold_until_pready", {30'd0, psel, penable}, 32'd3);
            check32("proto_stable_paddr", paddr, p_addr);
            check32("proto_stable_pwdata", pwdata, p_wdata);
            check32("proto_stable_pwrite", {31'd0, pwrite}, {31'd0, p_wr});
         end
      end
      p_psel  = psel && rst_n;
      p_pen   = penable;
      p_rdy   = pready;
      p_wr    = pwrite;
      p_addr  = paddr;
      p_wdata = pwdata;
   end

   // ---------------- driver tasks ----------------
   // Called just after a rising edge; returns just after a rising edge.
   task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, input int abort_after, input bit scramble,
                       output bit rdy_seen, output int lat, output logic [31:0] rd,
                       output bit er);
      sel = d; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
      t_dut = d; t_wr = wr; t_addr = addr; t_wdata = wd; t_k = 0; t_live = 1'b1;
      exempt = (abort_after >= 0) || scramble;
      rdy_seen = 1'b0; lat = 0; rd = 32'd0; er = 1'b0;
      for (int c = 1; c <= wait_of(d) + 6; c++) begin
         @(posedge clk); #1;
         if (abort_after >= 0 && c > abort_after) begin
            psel = 1'b0; penable = 1'b0; t_live = 1'b0;
            @(posedge clk); #1;
            exempt = 1'b0;
            return;
         end
         penable = 1'b1; t_k = c;
         if (scramble) begin
            paddr = $urandom; pwdata = $urandom; pwrite = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         if (pready) begin
            rdy_seen = 1'b1; lat = c; rd = prdata; er = pslverr;
            break;
         end
      end
      vectors++;
      if (!rdy_seen) begin
         miscompares++;
         $display("FAIL xfer_timeout: dut %0d addr %h got no PREADY expected PREADY", d, addr);
      end
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; t_live = 1'b0; exempt = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // ---------------- stimulus ----------------
   bit          rs, re;
   int          lat;
   logic [31:0] rd;

   initial begin
      psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; sel = 0;
      repeat (3) @(posedge clk);
      #1;
      check32("reset_state_dut0", {30'd0, st0}, 32'd0);
      check32("reset_state_dut2", {30'd0, st2}, 32'd0);
      check32("reset_pready_dut2", {31'd0, bus2.PREADY}, 32'd0);
      rst_n = 1'b1;
      idle(1);

      // One wait state: write then read back
      xfer(1, 1, 32'h08, 32'hDEADBEEF, -1, 0, rs, lat, rd, re);
      check32("w1_write_latency", lat, 32'd2);
      check32("w1_write_err", {31'd0, re}, 32'd0);
      xfer(1, 0, 32'h08, 32'd0, -1, 0, rs, lat, rd, re);
      check32("w1_read_latency", lat, 32'd2);
      check32("w1_read_data", rd, 32'hDEADBEEF);
      check32("w1_read_err", {31'd0, re}, 32'd0);

      // Zero wait, back-to-back
      xfer(0, 1, 32'h00, 32'h11, -1, 0, rs, lat, rd, re);
      check32("w0_write_latency", lat, 32'd1);
      xfer(0, 1, 32'h04, 32'h22, -1, 0, rs, lat, rd, re);
      xfer(0, 0, 32'h00, 32'd0, -1, 0, rs, lat, rd, re);
      check32("w0_read0", rd, 32'h11);
      check32("w0_read_latency", lat, 32'd1);
      xfer(0, 0, 32'h04, 32'd0, -1, 0, rs, lat, rd, re);
      check32("w0_read1", rd, 32'h22);

      // Errors: out of range and misaligned
      xfer(1, 1, 32'h40, 32'h5, -1, 0, rs, lat, rd, re);
      check32("err_oob_write", {31'd0, re}, 32'd1);
      xfer(1, 1, 32'h06, 32'h5, -1, 0, rs, lat, rd, re);
      check32("err_misaligned_write", {31'd0, re}, 32'd1);
      xfer(1, 0, 32'h40, 32'd0, -1, 0, rs, lat, rd, re);
      check32("err_oob_read_data", rd, 32'd0);
      check32("err_oob_read_err", {31'd0, re}, 32'd1);
      xfer(1, 0, 32'h04, 32'd0, -1, 0, rs, lat, rd, re);
      check32("err_reg1_unchanged", rd, 32'd0);
      xfer(1, 0, 32'h08, 32'd0, -1, 0, rs, lat, rd, re);
      check32("err_reg2_unchanged", rd, 32'hDEADBEEF);

      // Abort after one ACCESS cycle with three wait states
      xfer(2, 1, 32'h0C, 32'hA5, 1, 0, rs, lat, rd, re);
      check32("abort_no_pready", {31'd0, rs}, 32'd0);
      idle(1);
      xfer(2, 0, 32'h0C, 32'd0, -1, 0, rs, lat, rd, re);
      check32("abort_reg3_zero", rd, 32'd0);
      check32("w3_latency", lat, 32'd4);

      // Reset in the middle of an ACCESS that is about to complete
      xfer(1, 1, 32'h08, 32'h1234, -1, 0, rs, lat, rd, re);
      sel = 1; psel = 1; penable = 0; pwrite = 1; paddr = 32'h08; pwdata = 32'hFFFF;
      t_dut = 1; t_wr = 1; t_addr = 32'h08; t_wdata = 32'hFFFF; t_k = 0; t_live = 1;
      @(posedge clk); #1; penable = 1; t_k = 1;
      @(posedge clk); #1; t_k = 2;
      #1;
      check32("rst_pready_before", {31'd0, pready}, 32'd1);
      #1; rst_n = 1'b0; t_live = 0; exempt = 1;
      #1;
      check32("rst_pready_async", {31'd0, pready}, 32'd0);
      check32("rst_state_async", {30'd0, st1}, 32'd0);
      @(posedge clk); #1;
      psel = 0; penable = 0; rst_n = 1'b1;
      idle(1);
      exempt = 0;
      xfer(1, 0, 32'h08, 32'd0, -1, 0, rs, lat, rd, re);
      check32("rst_reg2_cleared", rd, 32'd0);

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         int          d, r, ab;
         bit          wr, sc;
         logic [31:0] a;
         d  = $urandom_range(0, 2);
         wr = 1'($urandom_range(0, 1));
         r  = $urandom_range(0, 9);
         if (r == 0)      a = ($urandom_range(0, 15) * 4) + $urandom_range(1, 3);
         else if (r == 1) a = $urandom_range(64, 300);
         else             a = $urandom_range(0, 15) * 4;
         ab = -1;
         if (wait_of(d) > 0 && $urandom_range(0, 9) == 0) ab = $urandom_range(1, wait_of(d));
         sc = ($urandom_range(0, 7) == 0);
         xfer(d, wr, a, $urandom, ab, sc, rs, lat, rd, re);
         idle($urandom_range(0, 2));
      end

      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
